// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: the IF/ID register layout and its bubble value.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holdable, flushable, async reset to the bubble value.
module if_id_reg
   import riscv_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t q_q, q_d;

   // Flush outranks hold so a redirect during a stall still squashes the slot.
   always_comb begin
      q_d = q_q;
      if (flush_i) begin
         q_d = IF_ID_BUBBLE;
      end else if (!hold_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= IF_ID_BUBBLE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, next-PC mux, IF/ID register.
// Define FETCH_PERF_CNT_EN to build the saturating fetch/bubble counters.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [31:0]      redirect_pc_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_rdata_i,
   output logic             id_valid_o,
   output logic [31:0]      id_instr_o,
   output logic [31:0]      id_pc_o,
   output logic [31:0]      id_pc4_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   logic [31:0] pc_q, pc_d, pc_plus4;
   logic        misalign_q, misalign_d;
   logic        run;
   if_id_t      if_d, if_q;

   assign pc_plus4 = pc_q + 32'd4;
   assign run      = !redirect_i && !stall_i;

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (redirect_i) begin
         pc_d       = {redirect_pc_i[31:2], 2'b00};
         misalign_d = |redirect_pc_i[1:0];
      end else if (!stall_i) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign if_d = '{valid: 1'b1, instr: imem_rdata_i, pc: pc_q, pc4: pc_plus4};

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (stall_i),
      .flush_i (redirect_i),
      .d_i     (if_d),
      .q_o     (if_q)
   );

   assign imem_addr_o = pc_q;
   assign id_valid_o  = if_q.valid;
   assign id_instr_o  = if_q.instr;
   assign id_pc_o     = if_q.pc;
   assign id_pc4_o    = if_q.pc4;
   assign misalign_o  = misalign_q;

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (run) begin
         if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end else begin
         if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   logic unused_run;
   assign unused_run   = run;
   assign fetch_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds a scoreboard queue.
module tb_fetch_stage;

   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall, redirect;
   logic [31:0]   redirect_pc;
   logic [31:0]   imem_addr, imem_rdata;
   logic          id_valid, misalign;
   logic [31:0]   id_instr, id_pc, id_pc4;
   logic [CW-1:0] fetch_cnt, bubble_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [31:0]   addr;
      logic          valid;
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [31:0]   pc4;
      logic          mis;
      logic [CW-1:0] fc;
      logic [CW-1:0] bc;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic [31:0]   m_pc;
   logic          m_valid, m_mis;
   logic [31:0]   m_instr, m_ipc, m_ipc4;
   logic [CW-1:0] m_fc, m_bc;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   assign imem_rdata = imem_word(imem_addr);

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_addr_o   (imem_addr),
      .imem_rdata_i  (imem_rdata),
      .id_valid_o    (id_valid),
      .id_instr_o    (id_instr),
      .id_pc_o       (id_pc),
      .id_pc4_o      (id_pc4),
      .misalign_o    (misalign),
      .fetch_cnt_o   (fetch_cnt),
      .bubble_cnt_o  (bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ipc4 = 32'h0;
      m_mis = 1'b0; m_fc = '0; m_bc = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".addr"},  imem_addr, 32'h0);
      chk({tag, ".valid"}, {31'b0, id_valid}, 32'h0);
      chk({tag, ".instr"}, id_instr, 32'h0000_0013);
      chk({tag, ".pc"},    id_pc, 32'h0);
      chk({tag, ".pc4"},   id_pc4, 32'h0);
      chk({tag, ".mis"},   {31'b0, misalign}, 32'h0);
      chk({tag, ".fc"},    32'(fetch_cnt), 32'h0);
      chk({tag, ".bc"},    32'(bubble_cnt), 32'h0);
   endtask

   // Drive one cycle, push the model's prediction, then pop and compare after the edge.
   task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
      exp_t e;
      stall = st; redirect = rd; redirect_pc = rpc;
      if (rd) begin
         m_pc = {rpc[31:2], 2'b00};
         m_valid = 1'b0; m_instr = 32'h0000_0013; m_ipc = 32'h0; m_ipc4 = 32'h0;
         m_mis = |rpc[1:0];
         if (m_bc != '1) m_bc = m_bc + 1'b1;
      end else if (st) begin
         m_mis = 1'b0;
         if (m_bc != '1) m_bc = m_bc + 1'b1;
      end else begin
         m_valid = 1'b1; m_instr = imem_word(m_pc); m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
         m_pc = m_pc + 32'd4;
         m_mis = 1'b0;
         if (m_fc != '1) m_fc = m_fc + 1'b1;
      end
      e.addr = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc = m_ipc; e.pc4 = m_ipc4;
      e.mis = m_mis;
`ifdef FETCH_PERF_CNT_EN
      e.fc = m_fc; e.bc = m_bc;
`else
      e.fc = '0; e.bc = '0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb.addr",  imem_addr, e.addr);
      chk("sb.valid", {31'b0, id_valid}, {31'b0, e.valid});
      chk("sb.instr", id_instr, e.instr);
      chk("sb.pc",    id_pc, e.pc);
      chk("sb.pc4",   id_pc4, e.pc4);
      chk("sb.mis",   {31'b0, misalign}, {31'b0, e.mis});
      chk("sb.fc",    32'(fetch_cnt), 32'(e.fc));
      chk("sb.bc",    32'(bubble_cnt), 32'(e.bc));
   endtask

   // Assert reset between edges and confirm outputs clear before the next edge.
   task automatic mid_cycle_reset(input string tag);
      stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals(tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #12;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      step(1'b0, 1'b0, 32'h0);
      chk("e1.instr", id_instr, 32'h0050_0093);
      chk("e1.pc4", id_pc4, 32'h4);
      step(1'b0, 1'b0, 32'h0);
      chk("e2.instr", id_instr, 32'h00A0_0113);
      chk("e2.pc", id_pc, 32'h4);

      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 32'h0);
         chk("stall.addr", imem_addr, 32'h8);
         chk("stall.pc", id_pc, 32'h4);
      end
      step(1'b0, 1'b0, 32'h0);
      chk("unstall.pc", id_pc, 32'h8);

      step(1'b1, 1'b1, 32'h40);
      chk("redir.addr", imem_addr, 32'h40);
      chk("redir.valid", {31'b0, id_valid}, 32'h0);
      chk("redir.instr", id_instr, 32'h0000_0013);
      step(1'b0, 1'b0, 32'h0);
      chk("redir.tgt", id_pc, 32'h40);

      step(1'b0, 1'b1, 32'h42);
      chk("mis.addr", imem_addr, 32'h40);
      chk("mis.pulse", {31'b0, misalign}, 32'h1);
      step(1'b0, 1'b0, 32'h0);
      chk("mis.clear", {31'b0, misalign}, 32'h0);

      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
      chk("wrap.pc4", id_pc4, 32'h0);
      chk("wrap.addr", imem_addr, 32'h0);

      mid_cycle_reset("midrst1");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      chk("cnt.fetch", 32'(fetch_cnt), 32'd5);
      chk("cnt.bubble", 32'(bubble_cnt), 32'd3);
`else
      chk("cnt.fetch", 32'(fetch_cnt), 32'd0);
      chk("cnt.bubble", 32'(bubble_cnt), 32'd0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic st, rd;
         logic [31:0] tgt;
         st  = ($urandom_range(3) == 0);
         rd  = ($urandom_range(7) == 0);
         tgt = $urandom & 32'h0000_0FFF;
         step(st, rd, tgt);
      end

      mid_cycle_reset("midrst2");
      step(1'b0, 1'b0, 32'h0);
      chk("post.instr", id_instr, 32'h0050_0093);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core, directly upstream of decode. Owns the program counter, drives the address of the combinational instruction memory, and registers the fetched word with its PC and PC+4 into the IF/ID pipeline register. Stall requests from the hazard unit and taken-branch/jump redirects from execute are handled here, with a bubble inserted on redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 32: width of the performance counters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall_i` in 1: hold PC and IF/ID for this cycle.
- `redirect_i` in 1: taken branch/jump resolved in execute.
- `redirect_pc_i` in 32: redirect target, the ALU result.
- `imem_addr_o` out 32: current PC; read address for the instruction memory.
- `imem_rdata_i` in 32: instruction word read combinationally at `imem_addr_o`.
- `id_valid_o` out 1: IF/ID holds a real instruction.
- `id_instr_o` out 32: IF/ID instruction.
- `id_pc_o` out 32: PC of `id_instr_o`.
- `id_pc4_o` out 32: `id_pc_o`+4; feeds the link-register write path.
- `misalign_o` out 1: one-cycle pulse, the last redirect target had bits [1:0] non-zero.
- `fetch_cnt_o` out CNT_W: valid instructions loaded into IF/ID.
- `bubble_cnt_o` out CNT_W: stall or redirect cycles.

## Operation
- Reset values: PC=`RESET_PC`, `id_valid_o`=0, `id_instr_o`=NOP (32'h0000_0013), `id_pc_o`=0, `id_pc4_o`=0, `misalign_o`=0, counters=0.
- `imem_addr_o` = PC, driven combinationally from the PC register.
- The following actions are evaluated in priority order at each rising edge; the first that applies is taken.
  - **REDIRECT** (`redirect_i`=1), regardless of `stall_i`:
    - PC <= {`redirect_pc_i`[31:2],2'b00}.
    - IF/ID <= bubble: valid=0, instr=NOP, pc=0, pc4=0.
    - `misalign_o` <= |`redirect_pc_i`[1:0].
  - **STALL** (`stall_i`=1, `redirect_i`=0):
    - PC and all IF/ID fields hold.
    - `misalign_o` <= 0.
  - **RUN**:
    - PC <= PC+4.
    - IF/ID <= {valid=1, `imem_rdata_i`, PC, PC+4}.
    - `misalign_o` <= 0.
- Arithmetic is unsigned 32-bit. PC+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, and `id_pc4_o` wraps identically.
- No internal state machine beyond the three-way priority above. The IF/ID register is the only pipelining.

## Timing
- Fetch latency is 1 cycle: the word addressed by PC in cycle n appears on `id_*` after edge n+1.
- Redirect penalty from this stage: 1 bubble. `id_valid_o`=0 for one cycle, then the target instruction follows on the next edge, provided there is no stall.
- Stall is level-sensitive and may last any number of cycles. The first RUN cycle after a stall resumes at the held PC.
- First cycle after reset release: `id_valid_o`=0. The word at `RESET_PC` appears after the first edge.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`. Redirects and stalls in flight are discarded.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_cnt_o` increments on every RUN edge.
  - `bubble_cnt_o` increments on every REDIRECT or STALL edge.
  - Both counters saturate at all-ones and reset to 0.
- `FETCH_PERF_CNT_EN` undefined:
  - Both ports remain present and are tied to 0.
  - No counter flops are synthesised.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0013.
  - `if_id_t` struct {valid, instr, pc, pc4}, reused by decode.
- One sub-module, `if_id_reg`: a holdable, flushable register of `if_id_t` with asynchronous active-low reset to the bubble value.
- PC register, next-PC mux and counters live in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0, imem words 0x00500093 at 0x0 and 0x00A00113 at 0x4. After release:
  - Edge 1: id={1, 0x00500093, 0x0, 0x4}.
  - Edge 2: id={1, 0x00A00113, 0x4, 0x8}.
- Stall for 3 cycles at PC=0x8: `imem_addr_o` stays 0x8 and `id_*` is unchanged. On release, id gets the word at 0x8 with pc=0x8.
- `redirect_i`=1 with `redirect_pc_i`=0x40, `stall_i`=1 in the same cycle:
  - Next edge: PC=0x40, `id_valid_o`=0, `id_instr_o`=0x00000013.
  - The edge after: id pc=0x40.
- Redirect to 0x42: PC=0x40, `misalign_o`=1 for exactly one cycle.
- Force PC to 0xFFFF_FFFC and run: id pc=0xFFFF_FFFC, pc4=0x0, next `imem_addr_o`=0x0.
- With `FETCH_PERF_CNT_EN`, apply 5 RUN + 2 STALL + 1 REDIRECT cycles: `fetch_cnt_o`=5, `bubble_cnt_o`=3. Assert `rst_n` low mid-cycle: all outputs return to their reset values before the next edge.
